// File: rtl/pipeline_pkg.sv
// Shared interrupt-injection encoding between the interrupt sequencer and instruction memory.
// INT_counter values and the micro-instruction words injected for each push step.
package pipeline_pkg;

  typedef enum logic [2:0] {
    INT_NORMAL       = 3'd0,
    INT_PUSH_PC_HIGH = 3'd1,
    INT_PUSH_PC_LOW  = 3'd2,
    INT_PUSH_FLAGS   = 3'd3,
    INT_DEFER        = 3'd4
  } int_state_e;

  localparam logic [15:0] PUSH_FLAGS_WORD   = 16'hF800;
  localparam logic [15:0] PUSH_PC_LOW_WORD  = 16'hF801;
  localparam logic [15:0] PUSH_PC_HIGH_WORD = 16'hF802;
  localparam logic [15:0] NOP_WORD          = 16'h0000;

  // Instruction memory substitutes this word for the fetched one while injecting.
  function automatic logic [15:0] injected_word(input int_state_e sel);
    case (sel)
      INT_PUSH_FLAGS:   injected_word = PUSH_FLAGS_WORD;
      INT_PUSH_PC_LOW:  injected_word = PUSH_PC_LOW_WORD;
      INT_PUSH_PC_HIGH: injected_word = PUSH_PC_HIGH_WORD;
      default:          injected_word = NOP_WORD;
    endcase
  endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on the interrupt request with a pending latch.
// A new edge wins over a clear on the same clock so no request is ever lost.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic clear,
  output logic pending
);

  logic int_req_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_req_d <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_d <= int_req;
      if (int_req && !int_req_d)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt front end: waits for a safe fetch boundary, then steps INT_counter through
// push-flags / push-PC-low / push-PC-high and redirects fetch to the interrupt vector.
module interrupt_sequencer
  import pipeline_pkg::*;
#(
  parameter int                  pc_width   = 32,
  parameter logic [pc_width-1:0] INT_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                int_req,
  input  logic                stall,
  input  logic                cs_ldm,
  input  logic                cs_call,
  input  logic                cs_rti,
  output logic [2:0]          INT_counter,
  output logic                pc_hold,
  output logic                vector_load,
  output logic [pc_width-1:0] vector_pc,
  output logic                in_isr
);

  int_state_e state;
  logic       pending;
  logic       boundary_ok;
  logic       enter_flags;

  int_edge_latch u_edge_latch (
    .clk     (clk),
    .rst     (rst),
    .int_req (int_req),
    .clear   (enter_flags),
    .pending (pending)
  );

  // A two-word LDM or an in-flight CALL would be split by injection, so wait them out.
  assign boundary_ok = !cs_ldm && !cs_call;
  assign enter_flags = !stall && boundary_ok &&
                       ((state == INT_NORMAL && pending && !in_isr) || state == INT_DEFER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INT_NORMAL;
      in_isr <= 1'b0;
    end else if (!stall) begin
      case (state)
        INT_NORMAL:
          if (pending && !in_isr)
            state <= boundary_ok ? INT_PUSH_FLAGS : INT_DEFER;
        INT_DEFER:
          if (boundary_ok)
            state <= INT_PUSH_FLAGS;
        INT_PUSH_FLAGS:   state <= INT_PUSH_PC_LOW;
        INT_PUSH_PC_LOW:  state <= INT_PUSH_PC_HIGH;
        INT_PUSH_PC_HIGH: begin
          state  <= INT_NORMAL;
          in_isr <= 1'b1;
        end
        default:          state <= INT_NORMAL;
      endcase
      if (cs_rti && in_isr)
        in_isr <= 1'b0;
    end
  end

  assign INT_counter = state;
  assign pc_hold     = (state == INT_PUSH_FLAGS) || (state == INT_PUSH_PC_LOW) ||
                       (state == INT_PUSH_PC_HIGH);
  // Pulses only on the cycle that actually leaves PUSH_PC_HIGH, so a stall cannot stretch it.
  assign vector_load = (state == INT_PUSH_PC_HIGH) && !stall;
  assign vector_pc   = INT_VECTOR;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus pushes per-cycle expectations from a
// behavioural model, an independent monitor pops and compares them mid-cycle.
module tb_interrupt_sequencer;

  localparam int          PCW = 32;
  localparam logic [31:0] VEC = 32'h0000_0100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           int_req = 1'b0;
  logic           stall = 1'b0;
  logic           cs_ldm = 1'b0;
  logic           cs_call = 1'b0;
  logic           cs_rti = 1'b0;
  logic [2:0]     INT_counter;
  logic           pc_hold;
  logic           vector_load;
  logic [PCW-1:0] vector_pc;
  logic           in_isr;

  interrupt_sequencer #(.pc_width(PCW), .INT_VECTOR(VEC)) dut (
    .clk         (clk),
    .rst         (rst),
    .int_req     (int_req),
    .stall       (stall),
    .cs_ldm      (cs_ldm),
    .cs_call     (cs_call),
    .cs_rti      (cs_rti),
    .INT_counter (INT_counter),
    .pc_hold     (pc_hold),
    .vector_load (vector_load),
    .vector_pc   (vector_pc),
    .in_isr      (in_isr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cnt;
    logic       hold;
    logic       vl;
    logic       isr;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  // Model: mode 0 idle, 1 deferred, 2 injecting with 'pushes_left' micro-instructions to go.
  int mode = 0;
  int pushes_left = 0;
  bit m_pend = 0;
  bit m_prev = 0;
  bit m_isr = 0;
  int vl_total = 0;
  int seq_total = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit req, input bit st, input bit ldm, input bit call,
                                input bit rti, input bit r);
    exp_t e;
    bit   rise;
    bit   enter;
    bit   isr_n;
    @(posedge clk);
    #2;
    int_req = req; stall = st; cs_ldm = ldm; cs_call = call; cs_rti = rti; rst = r;
    case (mode)
      0: e.cnt = 3'd0;
      1: e.cnt = 3'd4;
      default: e.cnt = (pushes_left == 3) ? 3'd3 : (pushes_left == 2) ? 3'd2 : 3'd1;
    endcase
    e.hold = (mode == 2);
    e.vl   = (mode == 2) && (pushes_left == 1) && !st;
    e.isr  = m_isr;
    e.pend = m_pend;
    sb.push_back(e);
    if (r) begin
      mode = 0; pushes_left = 0; m_pend = 0; m_prev = 0; m_isr = 0;
    end else begin
      rise  = req && !m_prev;
      enter = 0;
      isr_n = m_isr;
      if (!st) begin
        if (mode == 0) begin
          if (m_pend && !m_isr) begin
            if (ldm || call) mode = 1;
            else begin mode = 2; pushes_left = 3; enter = 1; end
          end
        end else if (mode == 1) begin
          if (!ldm && !call) begin mode = 2; pushes_left = 3; enter = 1; end
        end else begin
          if (pushes_left == 1) begin mode = 0; isr_n = 1; seq_total++; end
          else pushes_left--;
        end
        if (rti && m_isr) isr_n = 0;
      end
      m_isr  = isr_n;
      m_pend = rise ? 1'b1 : (enter ? 1'b0 : m_pend);
      m_prev = req;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(int_req, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && vector_load === 1'b1) vl_total++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("INT_counter", 32'(INT_counter), 32'(e.cnt));
        check_output("pc_hold", 32'(pc_hold), 32'(e.hold));
        check_output("vector_load", 32'(vector_load), 32'(e.vl));
        check_output("in_isr", 32'(in_isr), 32'(e.isr));
        check_output("pending", 32'(dut.u_edge_latch.pending), 32'(e.pend));
      end
    end
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output("vector_pc", vector_pc, VEC);

    // Single pulse, no stall.
    idle(2);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    idle(7);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    idle(2);

    // Deferred by a two-word LDM.
    apply_stimulus(1, 0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0);
    idle(6);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    idle(2);

    // Stall while pushing PC low.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    idle(2);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    idle(4);

    // Nested request held off until RTI, then RTI coinciding with a fresh edge.
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    idle(3);
    apply_stimulus(1, 0, 0, 0, 1, 0);
    idle(6);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1, 0);
    idle(6);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Reset in the middle of a sequence.
    apply_stimulus(1, 0, 0, 0, 0, 0);
    idle(2);
    apply_stimulus(1, 0, 0, 0, 0, 1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit req;
      req = ($urandom_range(0, 3) == 0) ? !int_req : int_req;
      apply_stimulus(req, $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 149) == 0);
    end
    idle(3);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", sb.size());
    end
    check_output("vector_load_count", 32'(vl_total), 32'(seq_total));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Front-end interrupt controller for the five-stage pipeline: detects an external interrupt request, waits for a safe fetch boundary, then drives the 3-bit `INT_counter` consumed by the instruction memory so that it injects the push-flags / push-PC-low / push-PC-high micro-instructions in that order. It freezes PC advance during injection, redirects fetch to the interrupt vector, and masks further interrupts until RTI.

## Interface
Parameters:
- `pc_width`, 32, width of PC and vector address.
- `INT_VECTOR`, 0, PC value loaded after the injection sequence.

Ports:
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `int_req` in 1: external interrupt request, level; rising edge = one request.
- `stall` in 1: pipeline fetch stall; sequencer holds state while high.
- `cs_ldm` in 1: fetched instruction is two-word LDM (immediate word still to come).
- `cs_call` in 1: CALL in flight; PC redirect pending.
- `cs_rti` in 1: RTI retiring this cycle.
- `INT_counter` out 3: injection selector to instruction memory (encoding below).
- `pc_hold` out 1: freeze PC register.
- `vector_load` out 1: one-cycle pulse, PC <= `INT_VECTOR`.
- `vector_pc` out `pc_width`: constant `INT_VECTOR`.
- `in_isr` out 1: interrupt being serviced; new requests not taken.

## Operation
- `INT_counter` encoding (fixed, shared with instruction memory): 0 NORMAL, 4 DEFER, 3 PUSH_FLAGS, 2 PUSH_PC_LOW, 1 PUSH_PC_HIGH. Values 5–7 never driven.
- Edge detect: register `int_req_d`; `pending` set when `int_req & ~int_req_d`.
- State machine (state register is `INT_counter`):
  - NORMAL: if `pending & ~in_isr & ~stall`: to DEFER if `cs_ldm | cs_call`, else to PUSH_FLAGS.
  - DEFER: to PUSH_FLAGS once `~cs_ldm & ~cs_call & ~stall`.
  - PUSH_FLAGS -> PUSH_PC_LOW -> PUSH_PC_HIGH -> NORMAL, one step per non-stalled cycle.
  - Leaving PUSH_PC_HIGH: `vector_load`=1 that cycle, `in_isr` set next edge.
- `pending` cleared on the edge entering PUSH_FLAGS; a new edge at or after that edge re-sets it (set wins over clear on the same edge) and is serviced after RTI.
- `cs_rti` clears `in_isr` on the next edge; if `pending`, the next sequence may start the cycle after.
- `pc_hold` = 1 in PUSH_FLAGS, PUSH_PC_LOW, PUSH_PC_HIGH; 0 in NORMAL and DEFER.
- `stall` freezes every register except `int_req_d` and `pending` set (edges never lost).

## Timing
- Reset values: `INT_counter`=0, `pc_hold`=0, `vector_load`=0, `in_isr`=0, `pending`=0, `int_req_d`=0.
- Reset mid-sequence returns to NORMAL at once; in-progress request is dropped.
- Latency, no stall/defer: edge sampled at edge N -> `pending` N; `INT_counter`=3 after N+1, 2 after N+2, 1 after N+3, 0 with `vector_load` pulse during cycle N+3..N+4, `in_isr`=1 after N+4.
- Injection lasts exactly 3 unstalled cycles; stall cycles extend it 1:1.
- `cs_rti` and a fresh edge on the same cycle: `in_isr` clears, `pending` sets; sequence starts the following cycle.
- `cs_rti` while `in_isr`=0: ignored.
- All outputs registered except `pc_hold`, `vector_load` (decoded from state, glitch-free on `clk`).

## Structure
- Shared package `pipeline_pkg`: `INT_counter` encoding constants (`INT_NORMAL`, `INT_DEFER`, `INT_PUSH_FLAGS`, `INT_PUSH_PC_LOW`, `INT_PUSH_PC_HIGH`) and the injected micro-instruction words, used by both this block and instruction memory.
- One sub-module natural: `int_edge_latch` (edge detect + set-priority pending latch).

## Test plan
- Single pulse, no stall: `int_req` 0->1 at cycle 2 -> `INT_counter` 3,2,1,0 on cycles 3–6, `pc_hold` high 3 cycles, one `vector_load`, `in_isr`=1.
- Defer: edge while `cs_ldm`=1 for 2 cycles -> `INT_counter`=4 for those cycles, then 3,2,1,0.
- Stall mid-sequence: `stall`=1 for 2 cycles while `INT_counter`=2 -> holds 2, then 1,0; exactly one `vector_load`.
- Nested request: second edge while `in_isr`=1 -> no injection; `cs_rti` pulse -> second 3,2,1,0 sequence begins next cycle.
- Reset mid-sequence: `rst`=1 while `INT_counter`=2 -> next edge all outputs at reset values, `pending`=0.
